interrupt_controller: RTL
=========================

# interrupt_controller

Interrupt front-end for the multi-cycle MIPS core; sits directly upstream of `ControlUnit` and drives its `int_state` and `int_respond` inputs. Each cycle it does the following:
- synchronises external request lines;
- latches rising edges as pending requests, filtered by a mask;
- waits for an instruction boundary (the control unit in its fetch state);
- issues a one-cycle `int_respond` so the control unit saves PC and diverts to the handler;
- holds off further interrupts until the return instruction completes.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of request lines (legal range 2..4).
- `FETCH_STATE`, 4'd0: `ControlUnit.current_state` encoding of the fetch state.
- `RETI_INSTR`, 32'h4200_0018: instruction word (ERET) that ends a handler.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  system clock; all state updates on its rising edge.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Requests and mask:
  - `irq`  in  NUM_IRQ  asynchronous external request lines, active-high.
  - `irq_mask`  in  NUM_IRQ  per-line enable, 1 = enabled, synchronous.
- From `ControlUnit`:
  - `current_state`  in  4  control unit's current state.
  - `executedInstr`  in  32  instruction word currently held by the control unit.
- Outputs:
  - `int_state`  out  2  controller state; feeds `ControlUnit.int_state`.
  - `int_respond`  out  1  one-cycle divert command; feeds `ControlUnit.int_respond`.
  - `int_cause`  out  2  index of the line being serviced.
  - `pending`  out  NUM_IRQ  latched, not-yet-serviced requests.

## Operation
- **Input path:** each `irq` bit passes through a 2-flop synchroniser, then a third flop for edge detection.
  - Rise = sync2 & ~sync3.
  - A rise sets `pending[i]`, regardless of mask.
- **Request:** `req` = |(`pending` & `irq_mask`).
- **Priority:** `sel` = lowest index i with `pending[i] & irq_mask[i]`.
- **States** (`int_state` encoding):
  - IDLE = 2'b00.
    - To PENDING when `req`.
  - PENDING = 2'b01.
    - To ENTER when `req` and `current_state == FETCH_STATE`.
    - `int_cause` <= `sel` on this transition.
    - To IDLE when `req` drops, e.g. masked off.
  - ENTER = 2'b10.
    - `int_respond` = 1.
    - `pending[int_cause]` clears at the end of this cycle.
    - Unconditionally to SERVICE next cycle.
  - SERVICE = 2'b11.
    - No nesting; new edges only accumulate in `pending`.
    - To IDLE when `executedInstr == RETI_INSTR` and `current_state == FETCH_STATE`.
- **Outputs:**
  - `int_respond` is a registered decode of ENTER; it is high for exactly one cycle per serviced interrupt.
  - `int_cause` holds its value from ENTER through SERVICE until the next PENDING->ENTER transition.
- **Simultaneous set/clear on the same bit:** a new rise on line i in the same cycle that ENTER clears `pending[i]` leaves `pending[i]` = 1. The set wins.
- **Mask changes:** mask changes take effect the following cycle. A masked pending bit stays latched and is serviced once unmasked.
- **Back-to-back interrupts:** if `req` is still true on return to IDLE, the state goes to PENDING on the next cycle. There is no direct SERVICE->PENDING transition.

## Timing
- **Reset** (`rst_n` low, asynchronous, any state including mid-ENTER or SERVICE):
  - `int_state` = 2'b00, `int_respond` = 0, `int_cause` = 0, `pending` = 0.
  - All synchroniser flops = 0.
  - An `irq` held high across reset deassertion registers as a rise.
- **Latency**, with `irq[i]` first sampled high at edge k:
  - `pending[i]` = 1 after edge k+2.
  - `int_state` = PENDING after edge k+3 (when unmasked).
  - ENTER is entered on the first subsequent edge where `current_state == FETCH_STATE`. Minimum is edge k+4.
- **ENTER duration:** ENTER lasts exactly one cycle.
- **Return:** SERVICE->IDLE takes one edge after the return condition is seen.
- **Pulse width:** `irq` pulses shorter than one clock period may be missed. Requests must be held for at least 2 cycles.

## Test plan
- **Single request:** `irq` = 4'b0001, `irq_mask` = 4'hF, `current_state` = 0 held.
  - `pending[0]` = 1 at k+2, PENDING at k+3, ENTER with `int_respond` = 1 at k+4, SERVICE at k+5.
  - `int_cause` = 0 and `pending` = 0 from k+5.
- **Priority:** `irq` rises 4'b1010 simultaneously.
  - Line 1 is serviced first (`int_cause` = 1) while `pending` = 4'b1000.
  - After `executedInstr` = 32'h4200_0018 with `current_state` = 0: IDLE, then PENDING, then `int_cause` = 3.
- **Boundary wait:** request pending while `current_state` = 4'd3 for 6 cycles.
  - State stays PENDING and `int_respond` stays 0.
  - ENTER occurs on the first edge with `current_state` = 0.
- **Mask:** `irq_mask` = 4'h0 with `irq[2]` rising.
  - `pending` = 4'b0100 and `int_state` stays IDLE.
  - Set `irq_mask[2]` = 1: PENDING the next cycle.
- **No nesting:** while in SERVICE, raise `irq[0]`.
  - `pending[0]` = 1, state stays SERVICE, no `int_respond`.
  - After return: re-enters PENDING and services line 0.
- **Reset mid-operation:** assert `rst_n` = 0 during ENTER.
  - All outputs 0 immediately, without waiting for `clk`.
  - After release with `irq` low: stays IDLE.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Interrupt front-end for the multi-cycle MIPS core. Synchronises external request lines,
// latches their rising edges as pending requests, waits for the control unit to reach an
// instruction boundary (its fetch state), then issues a one-cycle divert command. Further
// interrupts are held off until the handler's return instruction completes.
//
// Parameters:
//   NUM_IRQ      number of request lines (2..4)
//   FETCH_STATE  ControlUnit.current_state encoding of the fetch state
//   RETI_INSTR   instruction word that ends a handler (ERET)
//
// Ports:
//   clk            in   1        system clock, rising edge
//   rst_n          in   1        asynchronous active-low reset
//   irq            in   NUM_IRQ  asynchronous request lines, active-high
//   irq_mask       in   NUM_IRQ  per-line enable, 1 = enabled
//   current_state  in   4        control unit state
//   executedInstr  in   32       instruction word held by the control unit
//   int_state      out  2        controller state (IDLE/PENDING/ENTER/SERVICE)
//   int_respond    out  1        one-cycle divert command
//   int_cause      out  2        index of the line being serviced
//   pending        out  NUM_IRQ  latched, not-yet-serviced requests

module interrupt_controller #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [3:0]  FETCH_STATE = 4'd0,
    parameter logic [31:0] RETI_INSTR  = 32'h4200_0018
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [3:0]         current_state,
    input  logic [31:0]        executedInstr,
    output logic [1:0]         int_state,
    output logic               int_respond,
    output logic [1:0]         int_cause,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPending = 2'b01,
        StEnter   = 2'b10,
        StService = 2'b11
    } state_e;

    state_e             state_q;
    logic               int_respond_q;
    logic [1:0]         int_cause_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;
    logic [NUM_IRQ-1:0] sync3_q;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] active;
    logic               req;
    logic [1:0]         sel;
    logic               at_fetch;
    logic               at_reti;

    // sync3 exists only for edge detection; sync2 is the first metastability-safe stage.
    assign rise     = sync2_q & ~sync3_q;
    assign active   = pending_q & irq_mask;
    assign req      = |active;
    assign at_fetch = (current_state == FETCH_STATE);
    assign at_reti  = at_fetch && (executedInstr == RETI_INSTR);

    // Lowest-index active line wins: scan downwards so the last hit is the lowest.
    always_comb begin
        sel = 2'd0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel = 2'(i);
            end
        end
    end

    // Clear the serviced line at the end of ENTER; a rise in the same cycle is OR-ed in
    // afterwards so the new request is not lost.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (state_q == StEnter && int_cause_q == 2'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            int_respond_q <= 1'b0;
            int_cause_q   <= 2'd0;
            pending_q     <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            sync3_q       <= '0;
        end else begin
            sync1_q   <= irq;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_d;

            unique case (state_q)
                StIdle: begin
                    int_respond_q <= 1'b0;
                    if (req) begin
                        state_q <= StPending;
                    end
                end
                StPending: begin
                    if (req && at_fetch) begin
                        state_q       <= StEnter;
                        int_respond_q <= 1'b1;
                        int_cause_q   <= sel;
                    end else if (!req) begin
                        state_q       <= StIdle;
                        int_respond_q <= 1'b0;
                    end else begin
                        int_respond_q <= 1'b0;
                    end
                end
                StEnter: begin
                    state_q       <= StService;
                    int_respond_q <= 1'b0;
                end
                StService: begin
                    int_respond_q <= 1'b0;
                    // No nesting: new edges only accumulate in pending_q here.
                    if (at_reti) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    int_respond_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_state   = state_q;
    assign int_respond = int_respond_q;
    assign int_cause   = int_cause_q;
    assign pending     = pending_q;

endmodule
